regfile_sequencer: RTL and testbench
====================================

// Module: regfile_sequencer
// PURPOSE
//  Single-clock instruction-cycle sequencer and write-port arbiter for the 16x16 register file.
//  - Steps FETCH/DECODE/EXEC/write phases and drives the register file's state code, addresses and write strobes.
//  - Shares the one write port between PSP adjust, RSP adjust and ALU writeback, and computes new stack-pointer values.
//  - Selects the next PC and faults on stack overflow or underflow.
// PARAMETERS
//  PSP_BASE   48  parameter-stack empty value; full at PSP_BASE+DEPTH
//  RSP_BASE   56  return-stack empty value; full at RSP_BASE+DEPTH
//  DEPTH      8   entries per stack
// PORTS
//  c_CLOCK     in   1   sole clock, rising edge
//  c_RESET     in   1   asynchronous, active-high reset
//  i_RUN       in   1   leave IDLE and start fetching
//  i_HALT      in   1   sampled in FINAL: return to IDLE instead of FETCH
//  i_MEMREADY  in   1   instruction memory has data (FETCH handshake)
//  i_CLRFAULT  in   1   leave FAULT to IDLE
//  i_PC        in   16  current PC (register 0)
//  i_PSP       in   16  current PSP (register 1)
//  i_RSP       in   16  current RSP (register 2)
//  i_PSPOP     in   2   decode: 00 none, 01 push (+1), 10 pop (-1), 11 treated as none
//  i_RSPOP     in   2   as i_PSPOP for RSP
//  i_WBREQ     in   1   decode: ALU result written back
//  i_WBADDR    in   4   writeback register address
//  i_RADDR     in   4   decode: register read address
//  i_WBDATA    in   16  ALU result, valid in FINAL
//  i_BRANCH    in   1   take branch, valid in FINAL
//  i_BRTARGET  in   16  branch target
//  o_STATE     out  3   state code to register file
//  o_FETCH     out  1   instruction fetch request
//  o_RADDR     out  4   register read address
//  o_WADDR     out  4   register write address
//  o_WDATA     out  16  register write data
//  o_WRITE     out  1   data write enable (FINAL only)
//  o_PCDATA    out  16  next PC
//  o_PCWRITE   out  1   PC write enable
//  o_FAULT     out  2   00 none, 01 overflow, 10 underflow; sticky
// BEHAVIOUR
//  - Reset: state IDLE (code 0); every output 0; latched decode fields 0; pending SP writes dropped.
//  - Reset mid-cycle aborts the instruction immediately; no partial write completes.
//  - States and codes: IDLE=0, FETCH=2, DECODE=4, EXEC=5, SPWR=3, FINAL=1, FAULT=7.
//  - IDLE:
//    - i_RUN=1 -> FETCH.
//  - FETCH:
//    - o_FETCH=1; stays while i_MEMREADY=0; i_MEMREADY=1 -> DECODE next edge.
//  - DECODE: latch i_PSPOP, i_RSPOP, i_WBREQ, i_WBADDR and i_RADDR; o_RADDR follows the latched value.
//    - Fault check at this point: push with SP==BASE+DEPTH -> overflow; pop with SP==BASE -> underflow.
//    - PSP is checked before RSP. Any fault -> FAULT with no writes.
//  - EXEC: one cycle. Next state is SPWR if any SP op is pending, else FINAL.
//  - SPWR: the register file writes unconditionally in code 3, so SPWR is entered only with a pending op.
//    - One write per cycle, fixed priority PSP then RSP.
//    - o_WADDR=1 or 2; o_WDATA=SP+1 for push, SP-1 for pop, 16-bit wrap (unreachable after the fault check).
//    - Stays in SPWR while an op remains, then FINAL. Each SP op adds exactly 1 cycle.
//  - FINAL:
//    - o_WRITE=i_WBREQ(latched) with o_WADDR=i_WBADDR and o_WDATA=i_WBDATA.
//    - o_PCWRITE=1; o_PCDATA=i_BRANCH ? i_BRTARGET : i_PC+1 (wraps FFFF->0000).
//    - Writeback to register 0 wins over the PC update (register file suppresses the PC write).
//    - Next state: i_HALT ? IDLE : FETCH.
//  - FAULT: o_FAULT holds its code; all write strobes stay 0. i_CLRFAULT -> IDLE and clears o_FAULT.
//  - Write strobes are 0 outside SPWR/FINAL. o_WADDR/o_WDATA are 0 when no write is active.
//  - Latency with no SP ops: FETCH(1 with ready)+DECODE+EXEC+FINAL = 4 cycles; push+push = 6.
// TESTING
//  1. Reset then i_RUN=1, i_MEMREADY=1, no SP ops, WBREQ to r5=0x1234: o_STATE 0,2,4,5,1; r5=0x1234; PC 0->1.
//  2. PSP push + RSP pop, PSP=48, RSP=57: two SPWR cycles, writes r1=49 then r2=56; FINAL at cycle 6.
//  3. PSP=56 with push: overflow; state 7, o_FAULT=01, no writes; i_CLRFAULT -> IDLE, o_FAULT=00.
//  4. RSP=56 with pop: underflow; o_FAULT=10. Branch in FINAL to 0x0200: o_PCDATA=0x0200.
//  5. i_MEMREADY low for 3 cycles: FETCH held 3 extra cycles. WBADDR=0 with i_BRANCH: r0 = i_WBDATA.
//  6. c_RESET pulsed mid-SPWR: outputs 0 asynchronously, second pending SP write never issued; i_HALT in FINAL -> IDLE.

Source files
------------

// File: rtl/regfile_sequencer.sv
// Instruction-cycle sequencer and single write-port arbiter for the 16x16 register file.
// Outputs decode combinationally from the state register, so reset clears them asynchronously.
module regfile_sequencer #(
  parameter int PSP_BASE = 48,
  parameter int RSP_BASE = 56,
  parameter int DEPTH    = 8
) (
  input  logic        c_CLOCK,
  input  logic        c_RESET,
  input  logic        i_RUN,
  input  logic        i_HALT,
  input  logic        i_MEMREADY,
  input  logic        i_CLRFAULT,
  input  logic [15:0] i_PC,
  input  logic [15:0] i_PSP,
  input  logic [15:0] i_RSP,
  input  logic [1:0]  i_PSPOP,
  input  logic [1:0]  i_RSPOP,
  input  logic        i_WBREQ,
  input  logic [3:0]  i_WBADDR,
  input  logic [3:0]  i_RADDR,
  input  logic [15:0] i_WBDATA,
  input  logic        i_BRANCH,
  input  logic [15:0] i_BRTARGET,
  output logic [2:0]  o_STATE,
  output logic        o_FETCH,
  output logic [3:0]  o_RADDR,
  output logic [3:0]  o_WADDR,
  output logic [15:0] o_WDATA,
  output logic        o_WRITE,
  output logic [15:0] o_PCDATA,
  output logic        o_PCWRITE,
  output logic [1:0]  o_FAULT
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FINAL  = 3'd1,
    S_FETCH  = 3'd2,
    S_SPWR   = 3'd3,
    S_DECODE = 3'd4,
    S_EXEC   = 3'd5,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [15:0] PSP_EMPTY = 16'(PSP_BASE);
  localparam logic [15:0] PSP_FULL  = 16'(PSP_BASE + DEPTH);
  localparam logic [15:0] RSP_EMPTY = 16'(RSP_BASE);
  localparam logic [15:0] RSP_FULL  = 16'(RSP_BASE + DEPTH);

  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;

  state_t      state_q, state_d;
  logic [1:0]  psp_op_q, rsp_op_q;
  logic        wbreq_q;
  logic [3:0]  wbaddr_q;
  logic [3:0]  raddr_q;
  logic [1:0]  fault_q;
  logic [1:0]  dec_fault;
  logic        psp_pend, rsp_pend;
  logic        psp_clr, rsp_clr;

  // Latched op fields hold only push/pop; an op is cleared as its write issues.
  assign psp_pend = (psp_op_q == OP_PUSH) || (psp_op_q == OP_POP);
  assign rsp_pend = (rsp_op_q == OP_PUSH) || (rsp_op_q == OP_POP);

  always_comb begin
    dec_fault = 2'b00;
    if ((i_PSPOP == OP_PUSH) && (i_PSP == PSP_FULL))       dec_fault = 2'b01;
    else if ((i_PSPOP == OP_POP) && (i_PSP == PSP_EMPTY))  dec_fault = 2'b10;
    else if ((i_RSPOP == OP_PUSH) && (i_RSP == RSP_FULL))  dec_fault = 2'b01;
    else if ((i_RSPOP == OP_POP) && (i_RSP == RSP_EMPTY))  dec_fault = 2'b10;
  end

  always_comb begin
    state_d   = state_q;
    o_FETCH   = 1'b0;
    o_WADDR   = 4'd0;
    o_WDATA   = 16'd0;
    o_WRITE   = 1'b0;
    o_PCDATA  = 16'd0;
    o_PCWRITE = 1'b0;
    psp_clr   = 1'b0;
    rsp_clr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_RUN) state_d = S_FETCH;
      end
      S_FETCH: begin
        o_FETCH = 1'b1;
        if (i_MEMREADY) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = (dec_fault != 2'b00) ? S_FAULT : S_EXEC;
      end
      S_EXEC: begin
        state_d = (psp_pend || rsp_pend) ? S_SPWR : S_FINAL;
      end
      S_SPWR: begin
        // The register file writes unconditionally in this state code.
        if (psp_pend) begin
          o_WADDR = 4'd1;
          o_WDATA = (psp_op_q == OP_PUSH) ? i_PSP + 16'd1 : i_PSP - 16'd1;
          psp_clr = 1'b1;
          state_d = rsp_pend ? S_SPWR : S_FINAL;
        end else if (rsp_pend) begin
          o_WADDR = 4'd2;
          o_WDATA = (rsp_op_q == OP_PUSH) ? i_RSP + 16'd1 : i_RSP - 16'd1;
          rsp_clr = 1'b1;
          state_d = S_FINAL;
        end else begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        if (wbreq_q) begin
          o_WRITE = 1'b1;
          o_WADDR = wbaddr_q;
          o_WDATA = i_WBDATA;
        end
        o_PCWRITE = 1'b1;
        o_PCDATA  = i_BRANCH ? i_BRTARGET : i_PC + 16'd1;
        state_d   = i_HALT ? S_IDLE : S_FETCH;
      end
      S_FAULT: begin
        if (i_CLRFAULT) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge c_CLOCK or posedge c_RESET) begin
    if (c_RESET) begin
      state_q  <= S_IDLE;
      psp_op_q <= 2'b00;
      rsp_op_q <= 2'b00;
      wbreq_q  <= 1'b0;
      wbaddr_q <= 4'd0;
      raddr_q  <= 4'd0;
      fault_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        raddr_q <= i_RADDR;
        if (dec_fault == 2'b00) begin
          psp_op_q <= (i_PSPOP == 2'b11) ? 2'b00 : i_PSPOP;
          rsp_op_q <= (i_RSPOP == 2'b11) ? 2'b00 : i_RSPOP;
          wbreq_q  <= i_WBREQ;
          wbaddr_q <= i_WBADDR;
        end else begin
          fault_q <= dec_fault;
        end
      end
      if (psp_clr) psp_op_q <= 2'b00;
      if (rsp_clr) rsp_op_q <= 2'b00;
      if ((state_q == S_FAULT) && i_CLRFAULT) fault_q <= 2'b00;
    end
  end

  assign o_STATE = state_q;
  assign o_RADDR = raddr_q;
  assign o_FAULT = fault_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: walks the instruction cycle, SP arbitration,
// fault handling, fetch stalls, branch/PC wrap and mid-instruction reset.
module tb_regfile_sequencer;
  logic        c_CLOCK = 1'b0;
  logic        c_RESET = 1'b1;
  logic        i_RUN = 0, i_HALT = 0, i_MEMREADY = 0, i_CLRFAULT = 0;
  logic [15:0] i_PC = 0, i_PSP = 16'd48, i_RSP = 16'd56;
  logic [1:0]  i_PSPOP = 0, i_RSPOP = 0;
  logic        i_WBREQ = 0;
  logic [3:0]  i_WBADDR = 0, i_RADDR = 0;
  logic [15:0] i_WBDATA = 0;
  logic        i_BRANCH = 0;
  logic [15:0] i_BRTARGET = 0;
  logic [2:0]  o_STATE;
  logic        o_FETCH;
  logic [3:0]  o_RADDR, o_WADDR;
  logic [15:0] o_WDATA, o_PCDATA;
  logic        o_WRITE, o_PCWRITE;
  logic [1:0]  o_FAULT;

  int checks = 0;
  int errors = 0;

  regfile_sequencer dut (
    .c_CLOCK(c_CLOCK), .c_RESET(c_RESET), .i_RUN(i_RUN), .i_HALT(i_HALT),
    .i_MEMREADY(i_MEMREADY), .i_CLRFAULT(i_CLRFAULT), .i_PC(i_PC), .i_PSP(i_PSP),
    .i_RSP(i_RSP), .i_PSPOP(i_PSPOP), .i_RSPOP(i_RSPOP), .i_WBREQ(i_WBREQ),
    .i_WBADDR(i_WBADDR), .i_RADDR(i_RADDR), .i_WBDATA(i_WBDATA), .i_BRANCH(i_BRANCH),
    .i_BRTARGET(i_BRTARGET), .o_STATE(o_STATE), .o_FETCH(o_FETCH), .o_RADDR(o_RADDR),
    .o_WADDR(o_WADDR), .o_WDATA(o_WDATA), .o_WRITE(o_WRITE), .o_PCDATA(o_PCDATA),
    .o_PCWRITE(o_PCWRITE), .o_FAULT(o_FAULT)
  );

  always #5 c_CLOCK = ~c_CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge c_CLOCK);
    #1;
  endtask

  // Write-port outputs together: state, write strobe, address, data, PC strobe.
  task automatic check_wr(input string tag, input logic [2:0] st, input logic wr,
                          input logic [3:0] wa, input logic [15:0] wd, input logic pcw);
    check({tag, ".state"}, 32'(o_STATE), 32'(st));
    check({tag, ".write"}, 32'(o_WRITE), 32'(wr));
    check({tag, ".waddr"}, 32'(o_WADDR), 32'(wa));
    check({tag, ".wdata"}, 32'(o_WDATA), 32'(wd));
    check({tag, ".pcwrite"}, 32'(o_PCWRITE), 32'(pcw));
  endtask

  initial begin
    // Reset state
    #2;
    check_wr("reset", 3'd0, 1'b0, 4'd0, 16'd0, 1'b0);
    check("reset.fetch", 32'(o_FETCH), 32'd0);
    check("reset.fault", 32'(o_FAULT), 32'd0);
    check("reset.raddr", 32'(o_RADDR), 32'd0);
    step();
    c_RESET = 1'b0;

    // 1: plain instruction with writeback r5=0x1234, PC 0 -> 1
    i_RUN = 1; i_MEMREADY = 1; i_WBREQ = 1; i_WBADDR = 4'd5; i_RADDR = 4'd3;
    i_WBDATA = 16'h1234; i_PC = 16'd0;
    check("t1.idle", 32'(o_STATE), 32'd0);
    step();
    check("t1.fetch_state", 32'(o_STATE), 32'd2);
    check("t1.fetch_req", 32'(o_FETCH), 32'd1);
    i_RUN = 0;
    step();
    check("t1.decode", 32'(o_STATE), 32'd4);
    check("t1.decode_nofetch", 32'(o_FETCH), 32'd0);
    step();
    check("t1.exec", 32'(o_STATE), 32'd5);
    check("t1.raddr", 32'(o_RADDR), 32'd3);
    step();
    check_wr("t1.final", 3'd1, 1'b1, 4'd5, 16'h1234, 1'b1);
    check("t1.pcdata", 32'(o_PCDATA), 32'h0001);
    step();
    check("t1.refetch", 32'(o_STATE), 32'd2);
    i_PC = 16'd1;

    // 2: PSP push + RSP pop; FETCH counted as cycle 1, FINAL lands on cycle 6
    i_PSPOP = 2'b01; i_RSPOP = 2'b10; i_WBREQ = 0; i_PSP = 16'd48; i_RSP = 16'd57;
    step();
    check("t2.c2_decode", 32'(o_STATE), 32'd4);
    step();
    check("t2.c3_exec", 32'(o_STATE), 32'd5);
    i_PSPOP = 2'b00; i_RSPOP = 2'b00;
    step();
    check_wr("t2.c4_psp", 3'd3, 1'b0, 4'd1, 16'd49, 1'b0);
    i_PSP = 16'd49;
    step();
    check_wr("t2.c5_rsp", 3'd3, 1'b0, 4'd2, 16'd56, 1'b0);
    i_RSP = 16'd56;
    i_HALT = 1;
    step();
    check_wr("t2.c6_final", 3'd1, 1'b0, 4'd0, 16'd0, 1'b1);
    check("t2.pcdata", 32'(o_PCDATA), 32'h0002);
    step();
    check("t2.halt_idle", 32'(o_STATE), 32'd0);
    i_HALT = 0;

    // 3: PSP overflow, sticky until cleared
    i_PSP = 16'd56; i_PSPOP = 2'b01; i_RUN = 1;
    step(); i_RUN = 0;
    step();
    check("t3.decode", 32'(o_STATE), 32'd4);
    step();
    check_wr("t3.fault", 3'd7, 1'b0, 4'd0, 16'd0, 1'b0);
    check("t3.code", 32'(o_FAULT), 32'd1);
    step();
    check("t3.hold_state", 32'(o_STATE), 32'd7);
    check("t3.hold_code", 32'(o_FAULT), 32'd1);
    i_CLRFAULT = 1;
    step();
    check("t3.clr_state", 32'(o_STATE), 32'd0);
    check("t3.clr_code", 32'(o_FAULT), 32'd0);
    i_CLRFAULT = 0;

    // 4: RSP underflow, then both stacks faulting (PSP reported), then branch
    i_PSP = 16'd48; i_PSPOP = 2'b00; i_RSP = 16'd56; i_RSPOP = 2'b10; i_RUN = 1;
    step(); i_RUN = 0; step(); step();
    check("t4.udf_state", 32'(o_STATE), 32'd7);
    check("t4.udf_code", 32'(o_FAULT), 32'd2);
    i_CLRFAULT = 1; step(); i_CLRFAULT = 0;
    i_PSP = 16'd56; i_PSPOP = 2'b01; i_RSPOP = 2'b10; i_RUN = 1;
    step(); i_RUN = 0; step(); step();
    check("t4.prio_code", 32'(o_FAULT), 32'd1);
    i_CLRFAULT = 1; step(); i_CLRFAULT = 0;
    i_PSP = 16'd48; i_PSPOP = 2'b00; i_RSPOP = 2'b00;
    i_BRANCH = 1; i_BRTARGET = 16'h0200; i_HALT = 1; i_RUN = 1;
    step(); i_RUN = 0; step(); step(); step();
    check_wr("t4.br_final", 3'd1, 1'b0, 4'd0, 16'd0, 1'b1);
    check("t4.br_pcdata", 32'(o_PCDATA), 32'h0200);
    step();
    check("t4.halt", 32'(o_STATE), 32'd0);

    // 5: fetch stall, writeback to r0 alongside branch, PC wrap
    i_MEMREADY = 0; i_RUN = 1;
    step(); i_RUN = 0;
    check("t5.fetch", 32'(o_STATE), 32'd2);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5.stall", 32'(o_STATE), 32'd2);
    end
    i_MEMREADY = 1; i_WBREQ = 1; i_WBADDR = 4'd0; i_WBDATA = 16'hBEEF;
    step();
    check("t5.decode", 32'(o_STATE), 32'd4);
    step(); step();
    check_wr("t5.r0_final", 3'd1, 1'b1, 4'd0, 16'hBEEF, 1'b1);
    check("t5.br_pcdata", 32'(o_PCDATA), 32'h0200);
    i_BRANCH = 0; i_PC = 16'hFFFF;
    #1;
    check("t5.pc_wrap", 32'(o_PCDATA), 32'h0000);
    step();
    check("t5.halt", 32'(o_STATE), 32'd0);

    // 6: reset mid-SPWR drops the second pending write
    i_WBREQ = 0; i_PC = 16'd3; i_HALT = 0;
    i_PSP = 16'd48; i_RSP = 16'd56; i_PSPOP = 2'b01; i_RSPOP = 2'b01; i_RUN = 1;
    step(); i_RUN = 0; step(); step(); step();
    check_wr("t6.spwr1", 3'd3, 1'b0, 4'd1, 16'd49, 1'b0);
    #3 c_RESET = 1'b1;
    #1;
    check_wr("t6.async_rst", 3'd0, 1'b0, 4'd0, 16'd0, 1'b0);
    step();
    c_RESET = 1'b0;
    i_PSPOP = 2'b00; i_RSPOP = 2'b00;
    for (int k = 0; k < 2; k++) begin
      step();
      check_wr("t6.idle_after_rst", 3'd0, 1'b0, 4'd0, 16'd0, 1'b0);
    end
    i_RUN = 1; i_HALT = 1;
    step(); i_RUN = 0; step(); step(); step();
    check_wr("t6.no_sp_final", 3'd1, 1'b0, 4'd0, 16'd0, 1'b1);
    check("t6.pcdata", 32'(o_PCDATA), 32'h0004);
    step();
    check("t6.halt_idle", 32'(o_STATE), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
